// File: rtl/kernel_pkg.sv
// kernel_pkg: shared definitions for the kernel window unit.
// Holds the frame-sequencing FSM state type and the connectivity encoding
// used by the CONN8 parameter.
package kernel_pkg;

  // Connectivity encoding for the CONN8 parameter.
  localparam int unsigned CONN_CROSS = 0;  // 4-neighbour cross plus centre
  localparam int unsigned CONN_FULL  = 1;  // full 3x3 neighbourhood

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StStream,
    StFlush
  } kw_state_e;

endpackage

// File: rtl/kernel_line_buffer.sv
// kernel_line_buffer: one-row delay line.
// Ports:
//   clk  - clock
//   en   - shift enable; din enters and every entry moves one place
//   din  - pixel shifted in
//   dout - oldest entry, i.e. the value shifted in DEPTH shifts ago
// Contents are not reset; they are don't-care until refilled.
module kernel_line_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/kernel_window_unit.sv
// kernel_window_unit: streaming 3x3 (or cross) border detector.
// Each result is the centre pixel, or 0 when max-min over the neighbourhood
// reaches the threshold latched at the start of the frame.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   thresh                    - threshold, latched on the first pixel of a frame
//   s_valid/s_ready/s_data/s_last - raster-order pixel input stream
//   m_valid/m_ready/m_data/m_last - raster-order result stream
//   busy                      - a frame is in progress
//   frame_err                 - one-cycle pulse on a misplaced or missing s_last
module kernel_window_unit
  import kernel_pkg::*;
#(
  parameter int unsigned IMG_W       = 8,
  parameter int unsigned IMG_H       = 8,
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned CONN8       = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIXEL_WIDTH-1:0] thresh,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [PIXEL_WIDTH-1:0] s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [PIXEL_WIDTH-1:0] m_data,
  output logic                   m_last,
  output logic                   busy,
  output logic                   frame_err
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned CW   = $clog2(NPIX) + 1;
  localparam int unsigned XW   = $clog2(IMG_W);
  localparam int unsigned YW   = $clog2(IMG_H);

  localparam logic [CW-1:0] FillLast = CW'(IMG_W);           // index that ends FILL
  localparam logic [CW-1:0] FirstRes = CW'(IMG_W + 1);       // first index giving a result
  localparam logic [CW-1:0] LastIdx  = CW'(NPIX - 1);
  localparam logic [CW-1:0] EndCnt   = CW'(NPIX + IMG_W + 1); // all flush steps done

  kw_state_e state_q, state_d;
  logic [CW-1:0]          adv_cnt_q;  // pixels accepted plus flush steps taken
  logic [XW-1:0]          col_q;      // column of the next result
  logic [YW-1:0]          row_q;      // row of the next result
  logic [PIXEL_WIDTH-1:0] thresh_q;
  logic [PIXEL_WIDTH-1:0] win_q [3][3];  // [row: 0=top][col: 2=newest]
  logic [PIXEL_WIDTH-1:0] nw [3][3];     // window after the current shift
  logic [PIXEL_WIDTH-1:0] new_px [3];
  logic [PIXEL_WIDTH-1:0] din, lb1_out, lb2_out, res;
  logic m_valid_q, m_last_q, frame_err_q;
  logic [PIXEL_WIDTH-1:0] m_data_q;
  logic out_free, accept, flush_step, advance, produce, bad_last, miss_last, last_xfer;

  assign out_free   = !m_valid_q || m_ready;
  assign s_ready    = (state_q != StFlush) && out_free;
  assign accept     = s_valid && s_ready;
  assign flush_step = (state_q == StFlush) && (adv_cnt_q != EndCnt) && out_free;
  assign advance    = accept || flush_step;
  assign din        = accept ? s_data : '0;
  assign bad_last   = accept && s_last && (adv_cnt_q != LastIdx);
  assign miss_last  = accept && !s_last && (adv_cnt_q == LastIdx);
  assign produce    = advance && (adv_cnt_q >= FirstRes) && !bad_last;
  assign last_xfer  = m_valid_q && m_ready && m_last_q;

  kernel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIXEL_WIDTH)) u_lb1 (
    .clk  (clk),
    .en   (advance),
    .din  (din),
    .dout (lb1_out)
  );

  kernel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIXEL_WIDTH)) u_lb2 (
    .clk  (clk),
    .en   (advance),
    .din  (lb1_out),
    .dout (lb2_out)
  );

  assign new_px[0] = lb2_out;
  assign new_px[1] = lb1_out;
  assign new_px[2] = din;

  // Result is computed from the window as it will be after this shift so that
  // it is registered on the same edge that accepts pixel k+IMG_W+1.
  always_comb begin
    logic [PIXEL_WIDTH-1:0] cen, mx, mn, px;
    logic outside, sel;
    for (int r = 0; r < 3; r++) begin
      nw[r][0] = win_q[r][1];
      nw[r][1] = win_q[r][2];
      nw[r][2] = new_px[r];
    end
    cen = nw[1][1];
    mx  = cen;
    mn  = cen;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        sel = (CONN8 != CONN_CROSS) || (r == 1) || (c == 1);
        outside = ((r == 0) && (row_q == '0)) || ((r == 2) && (row_q == YW'(IMG_H - 1))) ||
                  ((c == 0) && (col_q == '0)) || ((c == 2) && (col_q == XW'(IMG_W - 1)));
        px = outside ? cen : nw[r][c];
        if (sel && (px > mx)) mx = px;
        if (sel && (px < mn)) mn = px;
      end
    end
    res = ((mx - mn) >= thresh_q) ? '0 : cen;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StFill;
      StFill:   if (accept && (adv_cnt_q == FillLast)) state_d = StStream;
      StStream: if (accept && (adv_cnt_q == LastIdx)) state_d = StFlush;
      StFlush:  if (last_xfer) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (bad_last) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      adv_cnt_q   <= '0;
      col_q       <= '0;
      row_q       <= '0;
      thresh_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_err_q <= bad_last || miss_last;
      if ((state_q == StIdle) && accept) thresh_q <= thresh;
      if (state_d == StIdle) adv_cnt_q <= '0;
      else if (advance)      adv_cnt_q <= adv_cnt_q + CW'(1);
      if (bad_last) begin
        // Abandon the frame: drop any pending result and realign the output raster.
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
        col_q     <= '0;
        row_q     <= '0;
      end else if (produce) begin
        m_valid_q <= 1'b1;
        m_data_q  <= res;
        m_last_q  <= (row_q == YW'(IMG_H - 1)) && (col_q == XW'(IMG_W - 1));
        if (col_q == XW'(IMG_W - 1)) begin
          col_q <= '0;
          row_q <= (row_q == YW'(IMG_H - 1)) ? '0 : row_q + YW'(1);
        end else begin
          col_q <= col_q + XW'(1);
        end
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= nw[r][c];
        end
      end
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign busy      = (state_q != StIdle);
  assign frame_err = frame_err_q;

endmodule
